// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer:
// RV32 opcode encodings and the sequencer state enum.
package pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    MEMWAIT
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the lw in EX
// and the source registers read by the instruction in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [6:0] id_opcode_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  logic uses_rs1;
  logic uses_rs2;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    unique case (1'b1)
      (id_opcode_i == OP_R),
      (id_opcode_i == OP_STORE),
      (id_opcode_i == OP_BRANCH): begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      (id_opcode_i == OP_LOAD),
      (id_opcode_i == OP_IMM): begin
        uses_rs1 = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 is never a real producer, so a load to x0 cannot stall
  assign load_use_o = ex_memread_i && (ex_rd_i != 5'd0)
    && ((uses_rs1 && (ex_rd_i == id_rs1_i))
     || (uses_rs2 && (ex_rd_i == id_rs2_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: boot hold, load-use stall, branch flush,
// data-memory freeze, timeout flag and debug counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [6:0]       id_opcode_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             pc_sel_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             memwb_flush_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [7:0]    BOOT_LAST = 8'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [7:0]      boot_cnt_q, boot_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic            stall_inc;
  logic            flush_inc;
  logic            load_use;
  logic            mem_wait;

  hazard_detect u_hazard (
    .id_opcode_i  (id_opcode_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .ex_memread_i (ex_memread_i),
    .ex_rd_i      (ex_rd_i),
    .load_use_o   (load_use)
  );

  assign mem_wait = mem_req_i && !mem_ready_i;

  always_comb begin
    pc_en_o       = 1'b1;
    pc_sel_o      = 1'b0;
    ifid_en_o     = 1'b1;
    idex_en_o     = 1'b1;
    exmem_en_o    = 1'b1;
    memwb_en_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    memwb_flush_o = 1'b0;
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    unique case (state_q)
      BOOT: begin
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        idex_en_o     = 1'b0;
        exmem_en_o    = 1'b0;
        memwb_en_o    = 1'b0;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        memwb_flush_o = 1'b1;
        boot_cnt_d    = boot_cnt_q + 8'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN, MEMWAIT: begin
        if (mem_wait) begin
          // freeze dominates; branch/hazard re-evaluated once ready
          pc_en_o       = 1'b0;
          ifid_en_o     = 1'b0;
          idex_en_o     = 1'b0;
          exmem_en_o    = 1'b0;
          memwb_flush_o = 1'b1;
          stall_inc     = 1'b1;
          state_d       = MEMWAIT;
          if (state_q == RUN) wait_cnt_d = WW'(1);
          else if (wait_cnt_q != WAIT_MAX)
            wait_cnt_d = wait_cnt_q + WW'(1);
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          if (ex_taken_i) begin
            pc_sel_o     = 1'b1;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            flush_inc    = 1'b1;
          end else if (load_use) begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
            stall_inc    = 1'b1;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    timeout_d   = timeout_q || (wait_cnt_d == WAIT_MAX);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: boot hold, hazards,
// branch flush, memory freeze, timeout and async reset.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam logic [8:0] V_BOOT = 9'b000000111;
  localparam logic [8:0] V_RUN  = 9'b101111000;
  localparam logic [8:0] V_LU   = 9'b000111010;
  localparam logic [8:0] V_TK   = 9'b111111110;
  localparam logic [8:0] V_FRZ  = 9'b000001001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, ex_rd;
  logic        ex_mr, taken, mreq, mrdy;
  logic        pc_en, pc_sel, ifid_en, idex_en;
  logic        exmem_en, memwb_en;
  logic        ifid_fl, idex_fl, memwb_fl;
  logic        tmo;
  logic [31:0] stall_cnt, flush_cnt;
  logic [8:0]  ctl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .BOOT_CYCLES (4),
    .MEM_TIMEOUT (64),
    .CNT_W       (32)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .id_opcode_i   (opc),
    .id_rs1_i      (rs1),
    .id_rs2_i      (rs2),
    .ex_memread_i  (ex_mr),
    .ex_rd_i       (ex_rd),
    .ex_taken_i    (taken),
    .mem_req_i     (mreq),
    .mem_ready_i   (mrdy),
    .pc_en_o       (pc_en),
    .pc_sel_o      (pc_sel),
    .ifid_en_o     (ifid_en),
    .idex_en_o     (idex_en),
    .exmem_en_o    (exmem_en),
    .memwb_en_o    (memwb_en),
    .ifid_flush_o  (ifid_fl),
    .idex_flush_o  (idex_fl),
    .memwb_flush_o (memwb_fl),
    .timeout_o     (tmo),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  assign ctl = {pc_en, pc_sel, ifid_en, idex_en, exmem_en,
                memwb_en, ifid_fl, idex_fl, memwb_fl};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    opc = 7'd0; rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
    ex_mr = 1'b0; taken = 1'b0; mreq = 1'b0; mrdy = 1'b0;
  endtask

  task automatic set_lu(input logic [6:0] op,
                        input logic [4:0] r1,
                        input logic [4:0] r2,
                        input logic [4:0] rd);
    opc = op; rs1 = r1; rs2 = r2; ex_rd = rd; ex_mr = 1'b1;
  endtask

  task automatic boot_seq(input string tag);
    for (int i = 0; i < 4; i++) begin
      #1 check({tag, "_boot"}, 32'(ctl), 32'(V_BOOT));
      cyc();
    end
    #1 check({tag, "_run"}, 32'(ctl), 32'(V_RUN));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_ctl", 32'(ctl), 32'(V_BOOT));
    check("rst_stall", stall_cnt, 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    cyc();
    rst_n = 1'b1;
    boot_seq("b0");
    check("b0_stall", stall_cnt, 32'd0);
    check("b0_flush", flush_cnt, 32'd0);

    // load-use and non-hazard variants
    set_lu(OP_R, 5'd5, 5'd7, 5'd5);
    #1 check("lu_add", 32'(ctl), 32'(V_LU));
    cyc(); idle();
    #1 check("lu_after", 32'(ctl), 32'(V_RUN));
    check("lu_cnt", stall_cnt, 32'd1);
    set_lu(OP_R, 5'd0, 5'd7, 5'd0);
    #1 check("lu_x0", 32'(ctl), 32'(V_RUN));
    cyc();
    set_lu(OP_JAL, 5'd5, 5'd5, 5'd5);
    #1 check("lu_jal", 32'(ctl), 32'(V_RUN));
    cyc();
    set_lu(OP_LOAD, 5'd1, 5'd5, 5'd5);
    #1 check("lu_ld_rs2", 32'(ctl), 32'(V_RUN));
    cyc();
    set_lu(OP_STORE, 5'd1, 5'd5, 5'd5);
    #1 check("lu_st_rs2", 32'(ctl), 32'(V_LU));
    cyc(); idle();
    mreq = 1'b1; mrdy = 1'b1;
    #1 check("req_rdy", 32'(ctl), 32'(V_RUN));
    cyc(); idle();
    #1 check("cnt_a", stall_cnt, 32'd2);
    check("fcnt_a", flush_cnt, 32'd0);

    // taken branch beats load-use
    set_lu(OP_R, 5'd5, 5'd7, 5'd5);
    taken = 1'b1;
    #1 check("tk_lu", 32'(ctl), 32'(V_TK));
    cyc(); idle();
    #1 check("tk_fcnt", flush_cnt, 32'd1);
    check("tk_scnt", stall_cnt, 32'd2);

    // memory freeze, branch suppressed in first cycle
    for (int i = 0; i < 3; i++) begin
      mreq = 1'b1; mrdy = 1'b0; taken = (i == 0);
      #1 check("frz", 32'(ctl), 32'(V_FRZ));
      cyc();
    end
    taken = 1'b0;
    mrdy = 1'b1;
    set_lu(OP_R, 5'd5, 5'd7, 5'd5);
    #1 check("rdy_lu", 32'(ctl), 32'(V_LU));
    check("frz_scnt", stall_cnt, 32'd5);
    check("frz_fcnt", flush_cnt, 32'd1);
    cyc(); idle();
    #1 check("rdy_scnt", stall_cnt, 32'd6);
    check("rdy_ctl", 32'(ctl), 32'(V_RUN));

    // timeout after 64 wait cycles
    for (int i = 1; i <= 70; i++) begin
      mreq = 1'b1; mrdy = 1'b0;
      #1 check($sformatf("tmo_%0d", i), 32'(tmo),
               (i >= 65) ? 32'd1 : 32'd0);
      cyc();
    end
    mrdy = 1'b1;
    #1 check("tmo_rdy", 32'(ctl), 32'(V_RUN));
    cyc(); idle();
    #1 check("tmo_stick", 32'(tmo), 32'd1);
    check("tmo_scnt", stall_cnt, 32'd76);
    cyc();
    #1 check("tmo_stick2", 32'(tmo), 32'd1);

    // async reset in the middle of a wait
    mreq = 1'b1; mrdy = 1'b0;
    cyc(); cyc();
    #1 check("mw_frz", 32'(ctl), 32'(V_FRZ));
    rst_n = 1'b0;
    #1 check("ar_ctl", 32'(ctl), 32'(V_BOOT));
    check("ar_scnt", stall_cnt, 32'd0);
    check("ar_fcnt", flush_cnt, 32'd0);
    check("ar_tmo", 32'(tmo), 32'd0);
    idle();
    cyc();
    rst_n = 1'b1;
    boot_seq("b1");
    check("b1_tmo", 32'(tmo), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
